// File: rtl/dmem_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_ctrl_if : MEM-stage pipeline and data-memory bus bundle for dmem_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
interface dmem_ctrl_if;
  logic        op_valid;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall;
  logic [31:0] read_data;
  logic        bus_err;
  logic [7:0]  last_latency;

  modport slave (
    input  op_valid, mem_read, mem_write, addr, wdata, mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, stall, read_data, bus_err,
           last_latency
  );

  modport master (
    output op_valid, mem_read, mem_write, addr, wdata, mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall, read_data, bus_err,
           last_latency
  );
endinterface
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_ctrl : MEM-stage req/ack data-memory controller with timeout
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  wire logic   clk,
  input  wire logic   reset,
  dmem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

  state_t      state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic        mem_read_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] read_data_q;
  logic        bus_err_q;
  logic [7:0]  last_latency_q;
  logic [7:0]  wait_cnt_q;
  logic        w_access;

  assign w_access = bus.op_valid & (bus.mem_read | bus.mem_write);

  assign bus.stall        = ((state_q == IDLE) & w_access) | (state_q == BUSY);
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.read_data    = read_data_q;
  assign bus.bus_err      = bus_err_q;
  assign bus.last_latency = last_latency_q;

  // wait_cnt_q holds the index of the current BUSY cycle (1 in the first one)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_addr_q     <= 32'd0;
      mem_wdata_q    <= 32'd0;
      read_data_q    <= 32'd0;
      bus_err_q      <= 1'b0;
      last_latency_q <= 8'd0;
      wait_cnt_q     <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_access) begin
            mem_addr_q  <= bus.addr;
            mem_wdata_q <= bus.wdata;
            mem_we_q    <= bus.mem_write;
            mem_read_q  <= bus.mem_read;
            mem_req_q   <= 1'b1;
            wait_cnt_q  <= 8'd1;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            if (mem_read_q) begin
              read_data_q <= bus.mem_rdata;
            end
            mem_req_q      <= 1'b0;
            last_latency_q <= wait_cnt_q;
            state_q        <= DONE;
          end else if (wait_cnt_q == C_TIMEOUT) begin
            if (mem_read_q) begin
              read_data_q <= 32'd0;
            end
            mem_req_q      <= 1'b0;
            bus_err_q      <= 1'b1;
            last_latency_q <= C_TIMEOUT;
            state_q        <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_ctrl : randomized scoreboard bench for dmem_ctrl (TIMEOUT = 4)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam int T = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          lat;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  dmem_ctrl_if bus ();

  dmem_ctrl #(.TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  // driver-side reference state
  logic [31:0] m_rd;
  logic        m_err;

  // monitor-side state
  bit          mon_en;
  logic        prev_req;
  int          stall_cnt;
  int          req_cnt;
  logic [31:0] last_rd;
  logic        last_err;
  exp_t        e_mon;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1 of the cycle in which the instruction sits in IDLE.
  task automatic issue(input bit is_load, input logic [31:0] a, input logic [31:0] wd,
                       input int lat, input logic [31:0] rdv, input bit stray);
    exp_t e;
    bit   acked;
    int   nb;
    acked = (lat >= 1) && (lat <= T);
    nb    = acked ? lat : T;
    if (acked) begin
      if (is_load) m_rd = rdv;
    end else begin
      if (is_load) m_rd = 32'd0;
      m_err = 1'b1;
    end
    e.addr = a; e.wdata = wd; e.we = !is_load; e.lat = nb; e.rd = m_rd; e.err = m_err;
    q.push_back(e);
    bus.op_valid  = 1'b1;
    bus.mem_read  = is_load;
    bus.mem_write = !is_load;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.mem_ack   = stray;
    bus.mem_rdata = $urandom;
    for (int k = 1; k <= nb; k++) begin
      @(posedge clk); #1;
      bus.mem_ack   = (k == lat);
      bus.mem_rdata = (k == lat) ? rdv : $urandom;
    end
    @(posedge clk); #1;
    bus.mem_ack   = stray;
    bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    bus.op_valid  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_ack   = 1'b0;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      bus.op_valid  = 1'($urandom);
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.addr      = $urandom;
      bus.wdata     = $urandom;
      bus.mem_ack   = 1'($urandom);
      bus.mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    bus.op_valid = 1'b0;
    bus.mem_ack  = 1'b0;
  endtask

  task automatic clear_model();
    q.delete();
    m_rd = 32'd0; m_err = 1'b0;
    last_rd = 32'd0; last_err = 1'b0;
    prev_req = 1'b0; stall_cnt = 0; req_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (bus.mem_req) begin
        if (q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
        else begin
          chk("mem_addr", bus.mem_addr, q[0].addr);
          chk("mem_we", {31'd0, bus.mem_we}, {31'd0, q[0].we});
          if (q[0].we) chk("mem_wdata", bus.mem_wdata, q[0].wdata);
        end
        req_cnt++;
      end
      if (bus.stall) stall_cnt++;
      if (prev_req && !bus.mem_req) begin
        if (q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else begin
          e_mon = q.pop_front();
          chk("read_data", bus.read_data, e_mon.rd);
          chk("last_latency", {24'd0, bus.last_latency}, 32'(e_mon.lat));
          chk("bus_err", {31'd0, bus.bus_err}, {31'd0, e_mon.err});
          chk("done_stall", {31'd0, bus.stall}, 32'd0);
          chk("stall_cycles", 32'(stall_cnt), 32'(e_mon.lat + 1));
          chk("req_cycles", 32'(req_cnt), 32'(e_mon.lat));
          last_rd  = e_mon.rd;
          last_err = e_mon.err;
        end
        stall_cnt = 0;
        req_cnt   = 0;
      end else if (q.size() == 0) begin
        chk("idle_stall", {31'd0, bus.stall}, 32'd0);
        chk("idle_read_data", bus.read_data, last_rd);
        chk("idle_bus_err", {31'd0, bus.bus_err}, {31'd0, last_err});
      end
      prev_req = bus.mem_req;
    end
  end

  initial begin
    mon_en = 1'b0;
    clear_model();
    reset = 1'b1;
    bus.op_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.addr = 32'd0; bus.wdata = 32'd0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_read_data", bus.read_data, 32'd0);
    chk("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
    chk("rst_last_latency", {24'd0, bus.last_latency}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    issue(1'b1, 32'h100, 32'h0, 1, 32'hCAFEF00D, 1'b0);
    nop(2);
    issue(1'b0, 32'h200, 32'h12345678, 3, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 32'h300, 32'h0, T, 32'hA5A5A5A5, 1'b0);
    nop(1);
    issue(1'b1, 32'h400, 32'h0, 0, 32'h0, 1'b0);
    issue(1'b1, 32'h500, 32'h0, 2, 32'h11111111, 1'b1);
    issue(1'b1, 32'h504, 32'h0, 1, 32'h22222222, 1'b1);
    nop(2);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) nop($urandom_range(1, 3));
      else issue(1'($urandom), $urandom, $urandom, $urandom_range(0, T + 2),
                 $urandom, 1'($urandom));
    end
    nop(3);

    // asynchronous reset in the middle of a BUSY wait
    mon_en = 1'b0;
    bus.op_valid = 1'b1; bus.mem_read = 1'b1; bus.mem_write = 1'b0;
    bus.addr = 32'h0000_0ABC; bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_req_before_reset", {31'd0, bus.mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("async_mem_addr", bus.mem_addr, 32'd0);
    chk("async_mem_wdata", bus.mem_wdata, 32'd0);
    chk("async_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("async_read_data", bus.read_data, 32'd0);
    chk("async_bus_err", {31'd0, bus.bus_err}, 32'd0);
    chk("async_last_latency", {24'd0, bus.last_latency}, 32'd0);
    bus.op_valid = 1'b0; bus.mem_read = 1'b0;
    #1;
    chk("async_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_model();
    mon_en = 1'b1;
    nop(1);
    issue(1'b1, 32'h600, 32'h0, 2, 32'h5A5A0001, 1'b0);
    issue(1'b0, 32'h604, 32'h77778888, 4, 32'h0, 1'b1);
    nop(3);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
